// File: rtl/systolic_skew_feeder.sv
// Per-lane skew FIFOs feeding a systolic array: rows are pushed in parallel, and
// each lane pops independently under data_start. A zero bubble is emitted whenever a lane does not pop.
module systolic_skew_feeder #(
    parameter int unsigned datawith   = 16,
    parameter int unsigned array_size = 8,
    parameter int unsigned fifo_depth = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           wr_en,
    input  logic [array_size*datawith-1:0] wr_row,
    output logic                           wr_ready,
    input  logic [array_size-1:0]          data_start,
    output logic [array_size*datawith-1:0] out_data,
    output logic [array_size-1:0]          out_valid,
    output logic                           empty,
    output logic                           overflow,
    output logic                           drain_done
);

    localparam int unsigned ptr_w = $clog2(fifo_depth);
    localparam int unsigned cnt_w = ptr_w + 1;
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(fifo_depth);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ptr_w-1:0]      wr_ptr;
    logic [ptr_w-1:0]      rd_ptr [array_size];
    logic [cnt_w-1:0]      count  [array_size];
    logic [datawith-1:0]   mem    [array_size][fifo_depth];
    logic [array_size-1:0] lane_full;
    logic [array_size-1:0] lane_nonempty;
    logic [array_size-1:0] pop;
    logic                  push;

    // Full check uses pre-pop counts, so a full lane rejects a push even while popping.
    always_comb begin
        for (int i = 0; i < int'(array_size); i++) begin
            lane_full[i]     = (count[i] == full_cnt);
            lane_nonempty[i] = (count[i] != '0);
            pop[i]           = data_start[i] & lane_nonempty[i] & ~flush;
        end
    end

    assign wr_ready = ~|lane_full;
    assign empty    = ~|lane_nonempty;
    assign push     = wr_en & wr_ready & ~flush;

    // Shared write pointer, per-lane read pointers and occupancy counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            for (int i = 0; i < int'(array_size); i++) begin
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            for (int i = 0; i < int'(array_size); i++) begin
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_w'(1);
            end
            for (int i = 0; i < int'(array_size); i++) begin
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + ptr_w'(1);
                end
                case ({push, pop[i]})
                    2'b10:   count[i] <= count[i] + cnt_w'(1);
                    2'b01:   count[i] <= count[i] - cnt_w'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by the counts alone.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < int'(array_size); i++) begin
                mem[i][wr_ptr] <= wr_row[i*datawith +: datawith];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= '0;
            overflow  <= 1'b0;
        end else if (flush) begin
            out_data  <= '0;
            out_valid <= '0;
            overflow  <= 1'b0;
        end else begin
            for (int i = 0; i < int'(array_size); i++) begin
                out_valid[i]                   <= pop[i];
                out_data[i*datawith +: datawith] <= pop[i] ? mem[i][rd_ptr[i]] : '0;
            end
            if (wr_en && !wr_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if ((data_start != '0) && !empty) state_d = STREAM;
            STREAM:  if (empty && !push && (data_start == '0)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    assign drain_done = (state_q == DONE);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: streaming, skewed starts, overflow,
// concurrent push/pop, flush priority and asynchronous reset.
module tb_systolic_skew_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         wr_en;
    logic [127:0] wr_row;
    logic         wr_ready;
    logic [7:0]   data_start;
    logic [127:0] out_data;
    logic [7:0]   out_valid;
    logic         empty;
    logic         overflow;
    logic         drain_done;

    int n_checks = 0;
    int n_fail   = 0;

    systolic_skew_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_ready   (wr_ready),
        .data_start (data_start),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .empty      (empty),
        .overflow   (overflow),
        .drain_done (drain_done)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mk_row(input int r);
        logic [127:0] w;
        for (int i = 0; i < 8; i++) w[i*16 +: 16] = 16'(16*r + i);
        return w;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_rows(input int first, input int n);
        wr_en = 1'b1;
        for (int r = first; r < first + n; r++) begin
            wr_row = mk_row(r);
            tick();
        end
        wr_en  = 1'b0;
        wr_row = '0;
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if (out_valid !== 8'h00 || out_data !== 128'h0) begin
            n_fail++; $display("FAIL reset_out: valid=%h data=%h required 0", out_valid, out_data);
        end
        n_checks++;
        if (overflow !== 1'b0 || drain_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: ovf=%b dd=%b required 0", overflow, drain_done);
        end
        n_checks++;
        if (wr_ready !== 1'b1 || empty !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: wr_ready=%b empty=%b required 1", wr_ready, empty);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if (drain_done !== 1'b0) begin
                n_fail++; $display("FAIL reset_release_dd: got %b required 0", drain_done);
            end
        end
    endtask

    task automatic test_stream;
        push_rows(0, 3);
        n_checks++;
        if (empty !== 1'b0) begin
            n_fail++; $display("FAIL stream_empty: got %b required 0", empty);
        end
        data_start = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            logic [127:0] exp_d;
            logic [7:0]   exp_v;
            exp_d = (k < 3) ? mk_row(k) : 128'h0;
            exp_v = (k < 3) ? 8'hFF : 8'h00;
            tick();
            n_checks++;
            if (out_data !== exp_d || out_valid !== exp_v || drain_done !== 1'b0) begin
                n_fail++;
                $display("FAIL stream_cycle%0d: data=%h valid=%h dd=%b required data=%h valid=%h dd=0",
                         k, out_data, out_valid, drain_done, exp_d, exp_v);
            end
        end
        data_start = 8'h00;
        tick();
        n_checks++;
        if (drain_done !== 1'b1) begin
            n_fail++; $display("FAIL stream_done: got %b required 1", drain_done);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (drain_done !== 1'b0) begin
                n_fail++; $display("FAIL stream_done_single%0d: got %b required 0", k, drain_done);
            end
        end
    endtask

    task automatic test_skew;
        int vcnt [8];
        for (int i = 0; i < 8; i++) vcnt[i] = 0;
        push_rows(0, 8);
        for (int c = 0; c < 16; c++) begin
            logic [127:0] exp_d;
            logic [7:0]   exp_v;
            exp_d = '0;
            exp_v = '0;
            for (int i = 0; i < 8; i++) begin
                data_start[i] = (i <= c);
                if (c >= i && c - i < 8) begin
                    exp_v[i]          = 1'b1;
                    exp_d[i*16 +: 16] = 16'(16*(c - i) + i);
                end
            end
            tick();
            for (int i = 0; i < 8; i++) vcnt[i] += int'(out_valid[i]);
            n_checks++;
            if (out_data !== exp_d || out_valid !== exp_v) begin
                n_fail++;
                $display("FAIL skew_cycle%0d: data=%h valid=%h required data=%h valid=%h",
                         c, out_data, out_valid, exp_d, exp_v);
            end
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (vcnt[i] != 8) begin
                n_fail++; $display("FAIL skew_count_lane%0d: got %0d required 8", i, vcnt[i]);
            end
        end
        data_start = 8'h00;
        tick();
        n_checks++;
        if (drain_done !== 1'b1) begin
            n_fail++; $display("FAIL skew_done: got %b required 1", drain_done);
        end
        tick();
    endtask

    task automatic test_overflow;
        push_rows(20, 8);
        n_checks++;
        if (wr_ready !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_full: wr_ready=%b ovf=%b required 0/0", wr_ready, overflow);
        end
        wr_en  = 1'b1;
        wr_row = mk_row(99);
        tick();
        wr_en  = 1'b0;
        n_checks++;
        if (overflow !== 1'b1 || wr_ready !== 1'b0) begin
            n_fail++; $display("FAIL ovf_set: ovf=%b wr_ready=%b required 1/0", overflow, wr_ready);
        end
        data_start = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            logic [127:0] exp_d;
            logic [7:0]   exp_v;
            exp_d = (k < 8) ? mk_row(20 + k) : 128'h0;
            exp_v = (k < 8) ? 8'hFF : 8'h00;
            tick();
            n_checks++;
            if (out_data !== exp_d || out_valid !== exp_v) begin
                n_fail++;
                $display("FAIL ovf_pop%0d: data=%h valid=%h required data=%h valid=%h",
                         k, out_data, out_valid, exp_d, exp_v);
            end
        end
        n_checks++;
        if (overflow !== 1'b1 || wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky: ovf=%b wr_ready=%b required 1/1", overflow, wr_ready);
        end
        data_start = 8'h00;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_flush_clear: got %b required 0", overflow);
        end
    endtask

    task automatic test_push_pop;
        logic [127:0] ra;
        logic [127:0] rb;
        ra = mk_row(40);
        rb = mk_row(41);
        push_rows(40, 1);
        wr_en      = 1'b1;
        wr_row     = rb;
        data_start = 8'h01;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (out_data !== {112'h0, ra[15:0]} || out_valid !== 8'h01) begin
            n_fail++; $display("FAIL pp_old: data=%h valid=%h required lane0=%h valid=01", out_data, out_valid, ra[15:0]);
        end
        tick();
        n_checks++;
        if (out_data !== {112'h0, rb[15:0]} || out_valid !== 8'h01) begin
            n_fail++; $display("FAIL pp_new: data=%h valid=%h required lane0=%h valid=01", out_data, out_valid, rb[15:0]);
        end
        tick();
        n_checks++;
        if (out_valid !== 8'h00 || out_data !== 128'h0) begin
            n_fail++; $display("FAIL pp_count: valid=%h data=%h required 0", out_valid, out_data);
        end
        data_start = 8'h00;
        flush      = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (empty !== 1'b1 || drain_done !== 1'b0) begin
            n_fail++; $display("FAIL pp_cleanup: empty=%b dd=%b required 1/0", empty, drain_done);
        end
    endtask

    task automatic test_flush;
        push_rows(50, 4);
        flush      = 1'b1;
        wr_en      = 1'b1;
        wr_row     = mk_row(60);
        data_start = 8'hFF;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        n_checks++;
        if (empty !== 1'b1 || out_valid !== 8'h00 || out_data !== 128'h0 || overflow !== 1'b0 || drain_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_state: empty=%b valid=%h data=%h ovf=%b dd=%b required 1/00/0/0/0",
                     empty, out_valid, out_data, overflow, drain_done);
        end
        tick();
        n_checks++;
        if (out_valid !== 8'h00 || drain_done !== 1'b0) begin
            n_fail++; $display("FAIL flush_discard: valid=%h dd=%b required 00/0", out_valid, drain_done);
        end
        data_start = 8'h00;
        tick();
        n_checks++;
        if (drain_done !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_done: got %b required 0", drain_done);
        end
    endtask

    task automatic test_async_reset;
        push_rows(70, 3);
        data_start = 8'hFF;
        tick();
        n_checks++;
        if (out_valid !== 8'hFF || out_data !== mk_row(70)) begin
            n_fail++; $display("FAIL ar_pre: valid=%h data=%h required FF/%h", out_valid, out_data, mk_row(70));
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 8'h00 || out_data !== 128'h0 || overflow !== 1'b0 || drain_done !== 1'b0) begin
            n_fail++; $display("FAIL ar_outputs: valid=%h data=%h ovf=%b dd=%b required 0", out_valid, out_data, overflow, drain_done);
        end
        n_checks++;
        if (empty !== 1'b1 || wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL ar_status: empty=%b wr_ready=%b required 1/1", empty, wr_ready);
        end
        #2;
        rst = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 8'h00 || out_data !== 128'h0) begin
            n_fail++; $display("FAIL ar_post_pop: valid=%h data=%h required 0", out_valid, out_data);
        end
        data_start = 8'h00;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if (drain_done !== 1'b0) begin
                n_fail++; $display("FAIL ar_no_done%0d: got %b required 0", k, drain_done);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        wr_en      = 1'b0;
        wr_row     = '0;
        data_start = '0;
        test_reset();
        test_stream();
        test_skew();
        test_overflow();
        test_push_pop();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 Parameter datawith, default 16, bit width of one data word.
REQ-002 Parameter array_size, default 8, number of lanes (rows of the systolic array).
REQ-003 Parameter fifo_depth, default 8, per-lane FIFO depth in words; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous clear of all lane contents and status.
REQ-007 wr_en  input  1  push one row (one word into every lane) this cycle.
REQ-008 wr_row  input  array_size*datawith  row to push; lane i = bits [i*datawith +: datawith].
REQ-009 wr_ready  output  1  high when a push is accepted this cycle.
REQ-010 data_start  input  array_size  per-lane pop enable, driven by systolic_control.
REQ-011 out_data  output  array_size*datawith  registered per-lane word into the array.
REQ-012 out_valid  output  array_size  registered per-lane valid qualifier.
REQ-013 empty  output  1  high when every lane holds zero words.
REQ-014 overflow  output  1  sticky; set when a push is attempted while wr_ready is low.
REQ-015 drain_done  output  1  one-cycle pulse when streaming completes.

Function
REQ-016 Each lane SHALL be an independent FIFO of fifo_depth words with its own read pointer, a shared write pointer, and a count of width clog2(fifo_depth)+1.
REQ-017 wr_ready SHALL be combinational: low when any lane count equals fifo_depth, high otherwise.
REQ-018 A push with wr_en=1 and wr_ready=1 SHALL write lane i of wr_row into lane i; the word SHALL be poppable from the next cycle. There is no same-cycle bypass.
REQ-019 A push with wr_en=1 and wr_ready=0 SHALL be dropped, change no lane, and set overflow.
REQ-020 Lane i SHALL pop when data_start[i]=1 and its count is greater than 0. On the next cycle, out_data lane i SHALL hold the popped word and out_valid[i] SHALL be 1. Latency is 1 cycle.
REQ-021 When data_start[i]=1 and lane i is empty, no pop SHALL occur. Next cycle, out_data lane i SHALL be 0 and out_valid[i] SHALL be 0 (zero bubble).
REQ-022 When data_start[i]=0, out_data lane i SHALL be 0 and out_valid[i] SHALL be 0 on the next cycle.
REQ-023 When a push and a pop occur in the same cycle on one lane, the lane count SHALL be unchanged. The full check uses the pre-pop count, so a push to a full lane is rejected even if that lane pops in the same cycle.
REQ-024 Pointers SHALL wrap modulo fifo_depth; counts SHALL never exceed fifo_depth or go below 0.
REQ-025 Control FSM states and transitions:
 - IDLE -> STREAM when data_start != 0 and any lane count > 0.
 - STREAM -> DONE when all lane counts are 0, no push is accepted that cycle, and data_start == 0.
 - DONE -> IDLE unconditionally.
REQ-026 drain_done SHALL be 1 exactly in the cycle the FSM is in DONE, and 0 otherwise.
REQ-027 empty SHALL be combinational: high when all lane counts are 0.
REQ-028 flush SHALL have priority over wr_en and data_start. On the next edge it SHALL:
 - zero all pointers and counts;
 - clear out_data, out_valid and overflow;
 - move the FSM to IDLE without asserting drain_done.
REQ-029 overflow SHALL clear only on rst or flush.

Reset
REQ-030 While rst=1, regardless of clk:
 - pointers and counts SHALL be 0 and the FSM SHALL be IDLE;
 - out_data, out_valid, overflow and drain_done SHALL be 0;
 - wr_ready and empty SHALL be 1.
REQ-031 Reset asserted mid-stream SHALL discard all queued words; the first post-reset pop SHALL see empty lanes.
REQ-032 Reset release SHALL not produce a drain_done pulse.

Verification
REQ-033 Push rows R0..R2 (lane i word = 16*row+i), then hold data_start=8'hFF -> out_data equals R0, R1, R2 on consecutive cycles starting 1 cycle after the first pop, then zero bubbles with out_valid=0, then exactly one drain_done pulse after data_start drops.
REQ-034 Skew: raise data_start bit i at cycle t0+i after pushing 8 rows -> lane i emits its first valid word at t0+i+1 and emits 8 valid words in total.
REQ-035 Fill all lanes to 8 words with data_start=0 -> wr_ready=0. A 9th push is dropped, overflow=1, and the following 8 pops return only the original 8 words.
REQ-036 With lane 0 holding 1 word, push and pop lane 0 in the same cycle -> count stays 1, out_data lane 0 = the old word, and the new word is emitted on the following pop.
REQ-037 Assert flush and wr_en together with 4 words queued -> next cycle empty=1, out_valid=0, overflow=0, the push is discarded, and no drain_done pulse.
REQ-038 Assert rst asynchronously between clock edges during STREAM -> outputs reach their reset values immediately, and after release a pop yields out_valid=0.
